// File: rtl/router_synchronizer_pkg.sv
// Shared definitions for the 1x3 router: destination address encodings and the default port timeout.
package router_synchronizer_pkg;

   localparam logic [1:0] ADDR_P0      = 2'b00;
   localparam logic [1:0] ADDR_P1      = 2'b01;
   localparam logic [1:0] ADDR_P2      = 2'b10;
   localparam logic [1:0] ADDR_INVALID = 2'b11;

   localparam int DEFAULT_TIMEOUT = 30;

endpackage

// File: rtl/router_synchronizer_timeout.sv
// Per-port watchdog: pulses soft_reset for one cycle after TIMEOUT consecutive edges of valid-but-unread data.
module router_sync_timeout #(
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic clock,
   input  logic reset,
   input  logic vld,
   input  logic read_enb,
   output logic soft_reset
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt        <= '0;
         soft_reset <= 1'b0;
      end else if (!vld || read_enb) begin
         cnt        <= '0;
         soft_reset <= 1'b0;
      end else if (cnt == CNT_LAST) begin
         // Wrap so the pulse repeats every TIMEOUT cycles while the port stays stalled.
         cnt        <= '0;
         soft_reset <= 1'b1;
      end else begin
         cnt        <= cnt + 1'b1;
         soft_reset <= 1'b0;
      end
   end

endmodule

// File: rtl/router_synchronizer.sv
// Glue between the router FSM and the three output FIFOs: address latch, write steering, full return, port timeouts.
module router_synchronizer
   import router_synchronizer_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CNT_W   = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] data_in,
   input  logic       detect_add,
   input  logic       full_0,
   input  logic       full_1,
   input  logic       full_2,
   input  logic       empty_0,
   input  logic       empty_1,
   input  logic       empty_2,
   input  logic       write_enb_reg,
   input  logic       read_enb_0,
   input  logic       read_enb_1,
   input  logic       read_enb_2,
   output logic [2:0] write_enb,
   output logic       fifo_full,
   output logic       vld_out_0,
   output logic       vld_out_1,
   output logic       vld_out_2,
   output logic       soft_reset_0,
   output logic       soft_reset_1,
   output logic       soft_reset_2
);

   logic [1:0] addr;

   always_ff @(posedge clock) begin
      if (reset) begin
         addr <= ADDR_P0;
      end else if (detect_add) begin
         addr <= data_in;
      end
   end

   // Steering uses the registered address, so a header captured this cycle only steers from the next one.
   always_comb begin
      write_enb = 3'b000;
      fifo_full = 1'b0;
      unique case (addr)
         ADDR_P0: begin
            write_enb = {2'b00, write_enb_reg};
            fifo_full = full_0;
         end
         ADDR_P1: begin
            write_enb = {1'b0, write_enb_reg, 1'b0};
            fifo_full = full_1;
         end
         ADDR_P2: begin
            write_enb = {write_enb_reg, 2'b00};
            fifo_full = full_2;
         end
         ADDR_INVALID: begin
            write_enb = 3'b000;
            fifo_full = 1'b0;
         end
         default: begin
            write_enb = 3'b000;
            fifo_full = 1'b0;
         end
      endcase
   end

   assign vld_out_0 = ~empty_0;
   assign vld_out_1 = ~empty_1;
   assign vld_out_2 = ~empty_2;

   router_sync_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout_0 (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld_out_0),
      .read_enb   (read_enb_0),
      .soft_reset (soft_reset_0)
   );

   router_sync_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout_1 (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld_out_1),
      .read_enb   (read_enb_1),
      .soft_reset (soft_reset_1)
   );

   router_sync_timeout #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout_2 (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld_out_2),
      .read_enb   (read_enb_2),
      .soft_reset (soft_reset_2)
   );

endmodule

// File: tb/tb_router_synchronizer.sv
// Directed bench for router_synchronizer: table of address/steering vectors plus timeout sequences.
module tb_router_synchronizer;

   localparam int TIMEOUT = 30;
   localparam int CNT_W   = 5;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] data_in;
   logic       detect_add;
   logic       full_0, full_1, full_2;
   logic       empty_0, empty_1, empty_2;
   logic       write_enb_reg;
   logic       read_enb_0, read_enb_1, read_enb_2;
   logic [2:0] write_enb;
   logic       fifo_full;
   logic       vld_out_0, vld_out_1, vld_out_2;
   logic       soft_reset_0, soft_reset_1, soft_reset_2;

   int n_checks = 0;
   int n_fail   = 0;

   router_synchronizer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock         (clock),
      .reset         (reset),
      .data_in       (data_in),
      .detect_add    (detect_add),
      .full_0        (full_0),
      .full_1        (full_1),
      .full_2        (full_2),
      .empty_0       (empty_0),
      .empty_1       (empty_1),
      .empty_2       (empty_2),
      .write_enb_reg (write_enb_reg),
      .read_enb_0    (read_enb_0),
      .read_enb_1    (read_enb_1),
      .read_enb_2    (read_enb_2),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .vld_out_0     (vld_out_0),
      .vld_out_1     (vld_out_1),
      .vld_out_2     (vld_out_2),
      .soft_reset_0  (soft_reset_0),
      .soft_reset_1  (soft_reset_1),
      .soft_reset_2  (soft_reset_2)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       load;
      logic [1:0] addr;
      logic       wer;
      logic [2:0] full;     // {full_2, full_1, full_0}
      logic [2:0] exp_we;
      logic       exp_ff;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_soft(input string name, input logic e0, input logic e1, input logic e2);
      check(name, {5'b0, soft_reset_2, soft_reset_1, soft_reset_0}, {5'b0, e2, e1, e0});
   endtask

   initial begin
      reset = 1'b1; data_in = 2'b00; detect_add = 1'b0; write_enb_reg = 1'b0;
      {full_2, full_1, full_0}    = 3'b000;
      {empty_2, empty_1, empty_0} = 3'b111;
      {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
      tick(); tick();
      reset = 1'b0;
      write_enb_reg = 1'b1;
      #1;
      check("reset_write_enb", {5'b0, write_enb}, 8'h01);
      check("reset_fifo_full", {7'b0, fifo_full}, 8'h00);
      check_soft("reset_soft", 1'b0, 1'b0, 1'b0);
      check("reset_vld", {5'b0, vld_out_2, vld_out_1, vld_out_0}, 8'h00);

      //         load addr  wer full    we      ff
      vecs[0] = {1'b1, 2'b10, 1'b1, 3'b000, 3'b100, 1'b0};
      vecs[1] = {1'b0, 2'b00, 1'b1, 3'b100, 3'b100, 1'b1};
      vecs[2] = {1'b0, 2'b00, 1'b1, 3'b011, 3'b100, 1'b0};
      vecs[3] = {1'b0, 2'b00, 1'b0, 3'b100, 3'b000, 1'b1};
      vecs[4] = {1'b1, 2'b11, 1'b1, 3'b111, 3'b000, 1'b0};
      vecs[5] = {1'b1, 2'b00, 1'b1, 3'b001, 3'b001, 1'b1};
      vecs[6] = {1'b1, 2'b01, 1'b1, 3'b010, 3'b010, 1'b1};
      vecs[7] = {1'b0, 2'b10, 1'b1, 3'b101, 3'b010, 1'b0};

      for (int i = 0; i < 8; i++) begin
         detect_add = vecs[i].load;
         data_in    = vecs[i].addr;
         tick();
         detect_add    = 1'b0;
         write_enb_reg = vecs[i].wer;
         {full_2, full_1, full_0} = vecs[i].full;
         #1;
         check($sformatf("vec%0d_write_enb", i), {5'b0, write_enb}, {5'b0, vecs[i].exp_we});
         check($sformatf("vec%0d_fifo_full", i), {7'b0, fifo_full}, {7'b0, vecs[i].exp_ff});
      end

      // Header and write in the same cycle: old address (01) steers until the edge.
      {full_2, full_1, full_0} = 3'b000;
      write_enb_reg = 1'b1;
      detect_add = 1'b1;
      data_in = 2'b10;
      #1;
      check("same_cycle_old_addr", {5'b0, write_enb}, 8'h02);
      tick();
      detect_add = 1'b0;
      data_in = 2'b00;
      #1;
      check("same_cycle_new_addr", {5'b0, write_enb}, 8'h04);

      // Port 2 timeout with ports 0/1 being read.
      {empty_2, empty_1, empty_0} = 3'b000;
      {read_enb_2, read_enb_1, read_enb_0} = 3'b011;
      #1;
      check("vld_all", {5'b0, vld_out_2, vld_out_1, vld_out_0}, 8'h07);
      for (int i = 1; i <= 2 * TIMEOUT + 1; i++) begin
         tick();
         check_soft($sformatf("p2_timeout_edge%0d", i), 1'b0, 1'b0, (i == TIMEOUT) || (i == 2 * TIMEOUT));
      end
      check("addr_kept_after_soft", {5'b0, write_enb}, 8'h04);

      // Port 1: a read at count 20 restarts the count.
      {empty_2, empty_1, empty_0} = 3'b111;
      {read_enb_2, read_enb_1, read_enb_0} = 3'b000;
      tick();
      empty_1 = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         check_soft($sformatf("p1_pre_read%0d", i), 1'b0, 1'b0, 1'b0);
      end
      read_enb_1 = 1'b1;
      tick();
      check_soft("p1_read_edge", 1'b0, 1'b0, 1'b0);
      read_enb_1 = 1'b0;
      for (int i = 1; i <= TIMEOUT + 1; i++) begin
         tick();
         check_soft($sformatf("p1_after_read%0d", i), 1'b0, (i == TIMEOUT), 1'b0);
      end

      // Reset at count 25 clears counter and address.
      empty_1 = 1'b1;
      tick();
      empty_1 = 1'b0;
      for (int i = 1; i <= 25; i++) tick();
      reset = 1'b1;
      tick();
      check("vld_during_reset", {7'b0, vld_out_1}, 8'h01);
      check_soft("soft_in_reset", 1'b0, 1'b0, 1'b0);
      check("addr_after_reset", {5'b0, write_enb}, 8'h01);
      reset = 1'b0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         check_soft($sformatf("p1_after_reset%0d", i), 1'b0, (i == TIMEOUT), 1'b0);
      end

      // Port going empty mid-count clears the counter.
      for (int i = 1; i <= 15; i++) tick();
      empty_1 = 1'b1;
      tick();
      check("vld1_empty", {7'b0, vld_out_1}, 8'h00);
      empty_1 = 1'b0;
      for (int i = 1; i <= TIMEOUT; i++) begin
         tick();
         check_soft($sformatf("p1_after_empty%0d", i), 1'b0, (i == TIMEOUT), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
